// File: rtl/search_sched_pkg.sv
// Shared types and defaults for the search scheduler.
// Imported by the arbiter and the scheduler top.
package search_sched_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 5;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESULT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// A tie goes to the requester that was not granted last.
module rr_arbiter2
  import search_sched_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_id,
  output logic       o_valid
);

  logic r_last;

  always_comb begin
    o_valid = |i_req;
    unique case (i_req)
      2'b10:   o_id = 1'b1;
      2'b11:   o_id = ~r_last;
      default: o_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_last <= 1'b1;
    end else if (i_update && o_valid) begin
      r_last <= o_id;
    end
  end

endmodule

// File: rtl/search_scheduler.sv
// Shares one binary-search engine between two requesters,
// sequencing Start/Done and aborting hung searches.
module search_scheduler
  import search_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] key0,
  input  logic [DATA_W-1:0] key1,
  output logic [1:0]        ack,
  output logic              eng_Start,
  output logic [DATA_W-1:0] eng_Input,
  output logic              eng_Reset,
  input  logic              eng_Ready,
  input  logic              eng_Done,
  input  logic              eng_Found,
  input  logic [ADDR_W-1:0] eng_Loc,
  output logic              res_valid,
  output logic              res_id,
  output logic              res_found,
  output logic              res_err,
  output logic [ADDR_W-1:0] res_loc
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t r_state;
  sched_state_t w_state_n;

  logic [WD_W-1:0]   r_wd;
  logic [1:0]        r_ack;
  logic              r_start;
  logic [DATA_W-1:0] r_key;
  logic              r_id;
  logic              r_abort;
  logic              r_valid;
  logic              r_res_id;
  logic              r_found;
  logic              r_err;
  logic [ADDR_W-1:0] r_loc;

  logic w_accept;
  logic w_take;
  logic w_timeout;
  logic w_arb_id;
  logic w_arb_valid;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .Reset    (Reset),
    .i_req    (req),
    .i_update (w_accept),
    .o_id     (w_arb_id),
    .o_valid  (w_arb_valid)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_take    = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (eng_Ready && w_arb_valid) begin
          w_accept  = 1'b1;
          w_state_n = S_START;
        end
      end
      S_START: w_state_n = S_WAIT;
      S_WAIT: begin
        if (eng_Done) begin
          w_take    = 1'b1;
          w_state_n = S_RESULT;
        end else if (r_wd == WD_LAST) begin
          w_timeout = 1'b1;
          w_state_n = S_RESULT;
        end
      end
      S_RESULT: w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wd     <= '0;
      r_ack    <= '0;
      r_start  <= 1'b0;
      r_key    <= '0;
      r_id     <= 1'b0;
      r_abort  <= 1'b0;
      r_valid  <= 1'b0;
      r_res_id <= 1'b0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_loc    <= '0;
    end else begin
      r_ack   <= w_accept ? (w_arb_id ? 2'b10 : 2'b01) : 2'b00;
      r_start <= (r_state == S_START);
      r_abort <= w_timeout;
      r_valid <= w_take | w_timeout;
      if (w_accept) begin
        r_id  <= w_arb_id;
        r_key <= w_arb_id ? key1 : key0;
      end
      // counting starts once the engine has actually seen Start
      if (r_state == S_START || r_start) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_take) begin
        r_res_id <= r_id;
        r_found  <= eng_Found;
        r_err    <= 1'b0;
        r_loc    <= eng_Found ? eng_Loc : '0;
      end else if (w_timeout) begin
        r_res_id <= r_id;
        r_found  <= 1'b0;
        r_err    <= 1'b1;
        r_loc    <= '0;
      end
    end
  end

  assign ack       = r_ack;
  assign eng_Start = r_start;
  assign eng_Input = r_key;
  assign eng_Reset = Reset | r_abort;
  assign res_valid = r_valid;
  assign res_id    = r_res_id;
  assign res_found = r_found;
  assign res_err   = r_err;
  assign res_loc   = r_loc;

endmodule

// File: doc/search_scheduler.md
# search_scheduler

Round-robin scheduler that shares the single binary-search engine (32-word × 8-bit sorted RAM) between two requesters. It accepts a search key from one requester at a time, sequences the engine's Start/Done handshake and returns Found/Loc tagged with the requester id. A watchdog resets the engine if a search never completes. It sits between the client logic and the search engine; it is the only driver of the engine's Start, Input and Reset.

## Interface
- DATA_W, 8, key / RAM word width
- ADDR_W, 5, engine location width (32 words)
- TIMEOUT, 64, max cycles waiting for eng_Done before abort (≥ 4)
- clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- req  in  2  per-requester search request (level, held until ack)
- key0, key1  in  DATA_W  search key of requester 0 / 1, stable while req high
- ack  out  2  one-cycle grant pulse to the accepted requester
- eng_Start  out  1  engine start pulse
- eng_Input  out  DATA_W  key presented to engine
- eng_Reset  out  1  engine reset (= Reset OR abort pulse)
- eng_Ready  in  1  engine idle and able to accept Start
- eng_Done, eng_Found  in  1  engine completion / hit flag
- eng_Loc  in  ADDR_W  engine hit location
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  requester that owns the result
- res_found, res_err  out  1  hit flag / timeout abort flag
- res_loc  out  ADDR_W  hit location (0 when not found or err)

## Operation
- States: S_IDLE, S_START, S_WAIT, S_RESULT.
- S_IDLE: if eng_Ready && |req, arbitrate, latch key and id, pulse ack[id] → S_START. Otherwise stay.
- Arbitration is round-robin on last_grant. With a single requester, that requester wins. With both requesting, the winner is the requester ≠ last_grant. last_grant resets to 1, so requester 0 wins the first tie.
- S_START: eng_Start=1 for exactly one cycle, clear watchdog → S_WAIT.
- eng_Input holds the latched key from S_START through S_RESULT. It keeps its last value in S_IDLE.
- S_WAIT: watchdog increments each cycle.
  - eng_Done=1: capture eng_Found and eng_Loc (Loc forced to 0 if not found) → S_RESULT.
  - Watchdog reaches TIMEOUT−1 without Done: eng_Reset=1 for one cycle, res_err=1, found=0, loc=0 → S_RESULT.
  - Done and timeout in the same cycle: Done wins, no abort.
- S_RESULT: res_valid=1 with res_id, res_found, res_loc, res_err stable this cycle → S_IDLE.
- eng_Done outside S_WAIT is ignored.
- A requester still asserting req after its ack is treated as a new request and re-arbitrated.
- Reset at any point:
  - state → S_IDLE, last_grant → 1, watchdog → 0.
  - ack, eng_Start, res_valid, res_id, res_found, res_err, res_loc and eng_Input are all 0.
  - eng_Reset=1 while Reset is high. Any in-flight search is dropped with no result.

## Timing
- All outputs registered except eng_Reset, which is Reset OR the registered abort pulse.
- req sampled high at edge k (S_IDLE, eng_Ready=1) → ack high in cycle k+1, eng_Start high in cycle k+2.
- eng_Done sampled at edge d → res_valid high in cycle d+1.
- Back-to-back throughput: a new ack can occur no earlier than the cycle after res_valid. This requires eng_Ready=1 again.
- Abort: res_valid (err) follows eng_Start by TIMEOUT+1 cycles. eng_Reset pulses coincident with the transition into S_RESULT.
- Requesters must drop req within the cycle after ack to avoid a duplicate search.

## Structure
- Package search_sched_pkg: DATA_W/ADDR_W defaults, state enum sched_state_t.
- Sub-module rr_arbiter2: 2-way round-robin with last_grant register, outputs grant id and valid.
- Watchdog counter width $clog2(TIMEOUT), inline.

## Test plan
Bench uses a behavioural engine model: sorted RAM {0,4,8,…,124}, Done asserted 6 cycles after Start, Ready=1 when idle, plus a stall mode that never asserts Done.

- Single request, req=2'b01, key0=8'd28 → ack=01 next cycle, eng_Start one cycle later, res_valid with id=0, found=1, loc=7, err=0.
- Miss, req=2'b10, key1=8'd29 → res id=1, found=0, loc=0, err=0.
- Simultaneous req=2'b11 after reset, key0=8, key1=12 → first result id=0 loc=2, second id=1 loc=3; then req=11 again → id=0 first.
- Stall mode, key0=8 → eng_Reset pulse and res_valid with err=1 exactly TIMEOUT+1 cycles after eng_Start; next request is serviced normally.
- Reset asserted 3 cycles into S_WAIT → no res_valid, all outputs 0, eng_Reset high. After release, req=01 is accepted normally.
- req held high 3 cycles past ack (req=01) → second search issued only after first res_valid; Done pulse in S_IDLE ignored.
